// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one result bit per clock.
// Start/busy/done handshake; invalid digits short-circuit straight to DONE with err set.

module bcd_to_binary_seq_digit_fix (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  // After the right shift a digit is at most 12, so the subtract cannot underflow.
  assign d_o = (d_i >= 4'd8) ? d_i - 4'd3 : d_i;
endmodule

module bcd_to_binary_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);
  localparam int BW = 4*DIGITS;
  localparam int W  = BW + BIN_W;
  localparam int CW = $clog2(BIN_W+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q;
  logic [W-1:0]      work_q, work_d, shifted;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, done_q, err_q, errp_q;
  logic [BIN_W-1:0]  bin_q;
  logic [DIGITS-1:0] bad_dig;

  assign shifted               = work_q >> 1;
  assign work_d[BIN_W-1:0]     = shifted[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_to_binary_seq_digit_fix u_fix (
      .d_i(shifted[BIN_W+4*g +: 4]),
      .d_o(work_d[BIN_W+4*g +: 4])
    );
    assign bad_dig[g] = bcd_in[4*g +: 4] > 4'd9;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      errp_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // The done cycle is still IDLE; a start there is dropped, not queued.
          if (start && !done_q) begin
            if (|bad_dig) begin
              work_q  <= '0;
              errp_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              work_q  <= {bcd_in, {BIN_W{1'b0}}};
              errp_q  <= 1'b0;
              cnt_q   <= CW'(BIN_W);
              busy_q  <= 1'b1;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          bin_q   <= work_q[BIN_W-1:0];
          err_q   <= errp_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Every valid operand is fully consumed after BIN_W steps.
  a_residue: assert property (@(posedge clk) disable iff (rst)
    state_q == DONE |-> work_q[W-1:BIN_W] == '0);

  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_q;
  assign err     = err_q;
endmodule
